// File: rtl/vm_core_param_pkg.sv
// ---------------------------------------------------------------------------
// vm_pkg: shared types and tables for the parametrised vending controller.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package vm_pkg;

  localparam int MAX_DENOM    = 16;
  localparam int MAX_PROD     = 16;
  localparam int DEF_CREDIT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } state_t;

  // Coin values indexed by denomination code; the first N_DENOM entries are used.
  localparam int unsigned DENOM_VAL [MAX_DENOM] = '{
    1, 2, 5, 10, 20, 50, 100, 200,
    500, 1000, 2000, 5000, 10000, 20000, 50000, 100000
  };

  localparam logic [DEF_CREDIT_W-1:0] DEF_PRICE [4] = '{8'd3, 8'd5, 8'd7, 8'd12};

endpackage

`default_nettype wire

// File: rtl/vm_core_param_if.sv
// ---------------------------------------------------------------------------
// vm_core_param_if: coin/selection inputs (vm_in) and product/change outputs (vm_out).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface vm_core_param_if #(
  parameter int CREDIT_W = 8
) ();

  logic [3:0]          money;
  logic                money_valid;
  logic [3:0]          product_code;
  logic                buy;
  logic                product_ready;

  logic [3:0]          ready_product_code;
  logic                product_valid;
  logic                busy;
  logic [3:0]          change_denomination_code;
  logic                change_valid;
  logic                no_change;
  logic                reject;
  logic [CREDIT_W-1:0] credit;

  modport master (
    output money, money_valid, product_code, buy, product_ready,
    input  ready_product_code, product_valid, busy, change_denomination_code,
           change_valid, no_change, reject, credit
  );

  modport slave (
    input  money, money_valid, product_code, buy, product_ready,
    output ready_product_code, product_valid, busy, change_denomination_code,
           change_valid, no_change, reject, credit
  );

endinterface

`default_nettype wire

// File: rtl/vm_core_param_greedy_step.sv
// ---------------------------------------------------------------------------
// vm_greedy_step: one step of the greedy change walk, shared by dry run and payout.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vm_greedy_step #(
  parameter int CREDIT_W = 8,
  parameter int INV_W    = 4
) (
  input  logic [CREDIT_W-1:0] rem,
  input  logic [3:0]          d,
  input  logic [INV_W-1:0]    inv,
  input  logic [CREDIT_W-1:0] val,
  output logic                take,
  output logic [CREDIT_W-1:0] next_rem,
  output logic [3:0]          next_d,
  output logic                fail
);

  always_comb begin
    take     = (rem != '0) && (rem >= val) && (inv != '0);
    next_rem = take ? (rem - val) : rem;
    fail     = !take && (rem != '0) && (d == 4'd0);
    // Stay on the same denomination after a take: it may be usable again.
    next_d   = (take || (d == 4'd0)) ? d : (d - 4'd1);
  end

endmodule

`default_nettype wire

// File: rtl/vm_core_param.sv
// ---------------------------------------------------------------------------
// vm_core_param: vending controller with coin inventory and feasibility-checked change.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vm_core_param
  import vm_pkg::*;
#(
  parameter int N_PRODUCTS = 4,
  parameter int N_DENOM    = 4,
  parameter int CREDIT_W   = DEF_CREDIT_W,
  parameter int INV_W      = 4,
  parameter int INIT_COINS = 4,
  parameter logic [CREDIT_W-1:0] PRICE [N_PRODUCTS] = DEF_PRICE
) (
  input  logic           clk,
  input  logic           rst,
  vm_core_param_if.slave vm
);

  localparam logic [3:0]       LAST_D     = 4'(N_DENOM - 1);
  localparam logic [INV_W-1:0] INV_MAX    = '1;
  localparam logic [INV_W-1:0] INV_INIT   = INV_W'(INIT_COINS);
  localparam logic [32:0]      CREDIT_MAX = (33'd1 << CREDIT_W) - 33'd1;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d, rem_q, rem_d;
  logic [3:0]          d_q, d_d, code_q, code_d;
  logic [INV_W-1:0]    inv_q [N_DENOM];
  logic [INV_W-1:0]    inv_d [N_DENOM];
  logic [INV_W-1:0]    tmp_inv_q [N_DENOM];
  logic [INV_W-1:0]    tmp_inv_d [N_DENOM];

  logic                product_valid_q, product_valid_d;
  logic [3:0]          ready_code_q, ready_code_d;
  logic                busy_q, busy_d;
  logic                change_valid_q, change_valid_d;
  logic [3:0]          change_code_q, change_code_d;
  logic                no_change_q, no_change_d;
  logic                reject_q, reject_d;

  logic                coin_ok, buy_ok;
  logic [CREDIT_W-1:0] coin_val, buy_price, code_price, d_val, credit_tmp;
  logic [32:0]         coin_sum;
  logic [INV_W-1:0]    d_inv;
  logic                take, fail;
  logic [CREDIT_W-1:0] next_rem;
  logic [3:0]          next_d;

  // Table lookups by code; loops keep out-of-range codes from indexing past the tables.
  always_comb begin
    coin_ok    = 1'b0;
    coin_val   = '0;
    coin_sum   = '0;
    d_val      = '0;
    d_inv      = '0;
    buy_ok     = 1'b0;
    buy_price  = '0;
    code_price = '0;
    for (int i = 0; i < N_DENOM; i++) begin
      if (vm.money == 4'(i)) begin
        coin_ok  = 1'b1;
        coin_val = CREDIT_W'(DENOM_VAL[i]);
        coin_sum = 33'(credit_q) + 33'(DENOM_VAL[i]);
      end
      if (d_q == 4'(i)) begin
        d_val = CREDIT_W'(DENOM_VAL[i]);
        d_inv = (state_q == CHECK) ? tmp_inv_q[i] : inv_q[i];
      end
    end
    for (int i = 0; i < N_PRODUCTS; i++) begin
      if (vm.product_code == 4'(i)) begin
        buy_ok    = 1'b1;
        buy_price = PRICE[i];
      end
      if (code_q == 4'(i)) begin
        code_price = PRICE[i];
      end
    end
  end

  vm_greedy_step #(
    .CREDIT_W (CREDIT_W),
    .INV_W    (INV_W)
  ) u_step (
    .rem      (rem_q),
    .d        (d_q),
    .inv      (d_inv),
    .val      (d_val),
    .take     (take),
    .next_rem (next_rem),
    .next_d   (next_d),
    .fail     (fail)
  );

  always_comb begin
    state_d         = state_q;
    credit_d        = credit_q;
    rem_d           = rem_q;
    d_d             = d_q;
    code_d          = code_q;
    inv_d           = inv_q;
    tmp_inv_d       = tmp_inv_q;
    product_valid_d = product_valid_q;
    ready_code_d    = ready_code_q;
    change_valid_d  = 1'b0;
    change_code_d   = '0;
    no_change_d     = 1'b0;
    reject_d        = 1'b0;
    credit_tmp      = credit_q;

    unique case (state_q)
      IDLE: begin
        if (vm.money_valid && coin_ok) begin
          if (coin_sum <= CREDIT_MAX) begin
            credit_tmp = credit_q + coin_val;
            for (int i = 0; i < N_DENOM; i++) begin
              if ((vm.money == 4'(i)) && (inv_q[i] != INV_MAX)) begin
                inv_d[i] = inv_q[i] + INV_W'(1);
              end
            end
          end else begin
            change_valid_d = 1'b1;
            change_code_d  = vm.money;
          end
        end
        credit_d = credit_tmp;
        // The coin of this same cycle already counts toward the purchase.
        if (vm.buy) begin
          if (!buy_ok || (credit_tmp < buy_price)) begin
            reject_d = 1'b1;
          end else begin
            code_d    = vm.product_code;
            rem_d     = credit_tmp - buy_price;
            tmp_inv_d = inv_d;
            d_d       = LAST_D;
            state_d   = CHECK;
          end
        end
      end

      CHECK: begin
        if (rem_q == '0) begin
          state_d         = VEND;
          product_valid_d = 1'b1;
          ready_code_d    = code_q;
        end else if (take) begin
          rem_d = next_rem;
          for (int i = 0; i < N_DENOM; i++) begin
            if (d_q == 4'(i)) tmp_inv_d[i] = tmp_inv_q[i] - INV_W'(1);
          end
        end else if (fail) begin
          no_change_d = 1'b1;
          state_d     = IDLE;
        end else begin
          d_d = next_d;
        end
      end

      VEND: begin
        if (vm.product_ready) begin
          product_valid_d = 1'b0;
          credit_d        = credit_q - code_price;
          rem_d           = credit_q - code_price;
          d_d             = LAST_D;
          state_d         = CHANGE;
        end
      end

      CHANGE: begin
        if (rem_q == '0) begin
          state_d = IDLE;
        end else if (take) begin
          change_valid_d = 1'b1;
          change_code_d  = d_q;
          credit_d       = credit_q - d_val;
          rem_d          = next_rem;
          for (int i = 0; i < N_DENOM; i++) begin
            if (d_q == 4'(i)) inv_d[i] = inv_q[i] - INV_W'(1);
          end
        end else begin
          d_d = next_d;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      credit_q        <= '0;
      rem_q           <= '0;
      d_q             <= '0;
      code_q          <= '0;
      product_valid_q <= 1'b0;
      ready_code_q    <= '0;
      busy_q          <= 1'b0;
      change_valid_q  <= 1'b0;
      change_code_q   <= '0;
      no_change_q     <= 1'b0;
      reject_q        <= 1'b0;
      for (int i = 0; i < N_DENOM; i++) begin
        inv_q[i]     <= INV_INIT;
        tmp_inv_q[i] <= INV_INIT;
      end
    end else begin
      state_q         <= state_d;
      credit_q        <= credit_d;
      rem_q           <= rem_d;
      d_q             <= d_d;
      code_q          <= code_d;
      product_valid_q <= product_valid_d;
      ready_code_q    <= ready_code_d;
      busy_q          <= busy_d;
      change_valid_q  <= change_valid_d;
      change_code_q   <= change_code_d;
      no_change_q     <= no_change_d;
      reject_q        <= reject_d;
      inv_q           <= inv_d;
      tmp_inv_q       <= tmp_inv_d;
    end
  end

  assign vm.ready_product_code       = ready_code_q;
  assign vm.product_valid            = product_valid_q;
  assign vm.busy                     = busy_q;
  assign vm.change_denomination_code = change_code_q;
  assign vm.change_valid             = change_valid_q;
  assign vm.no_change                = no_change_q;
  assign vm.reject                   = reject_q;
  assign vm.credit                   = credit_q;

endmodule

`default_nettype wire
